// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM/blink generators and pwm_capture.
// Holds the default timeout, the counter-width rule and the FSM state encoding.
package pwm_pkg;

  // 4 s at 12 MHz
  localparam int MAX_TICKS_DEFAULT = 48_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  // Counter width able to hold 0..max_ticks
  function automatic int cnt_width(input int max_ticks);
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// pwm_input_conditioner: synchronizes the asynchronous pin and, when the
// PWM_CAPTURE_GLITCH_FILTER_EN macro is defined, suppresses pulses shorter
// than FILTER_TICKS cycles. Without the macro lvl_o is the last sync stage.
module pwm_input_conditioner #(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  , parameter int FILTER_TICKS = 4
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic lvl_o
);

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic stage_d;
    logic stage_q;
    if (gi == 0) begin : g_first
      assign stage_d = pwm_i;
    end else begin : g_rest
      assign stage_d = g_sync[gi-1].stage_q;
    end
    // Retime the pin one stage per clock
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stage_q <= 1'b0;
      else       stage_q <= stage_d;
    end
  end

  logic sync_out;
  assign sync_out = g_sync[SYNC_STAGES-1].stage_q;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS) : 1;

  logic          lvl_q, lvl_d;
  logic [FW-1:0] flt_q, flt_d;

  // Follow the synced input only after it disagrees for FILTER_TICKS cycles in a row
  always_comb begin
    lvl_d = lvl_q;
    flt_d = '0;
    if (sync_out != lvl_q) begin
      if (flt_q == FW'(FILTER_TICKS - 1)) begin
        lvl_d = sync_out;
      end else begin
        flt_d = flt_q + 1'b1;
      end
    end
  end

  // Filter state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_q <= 1'b0;
      flt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      flt_q <= flt_d;
    end
  end

  assign lvl_o = lvl_q;
`else
  assign lvl_o = sync_out;
`endif

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a pulse train in clock ticks
// and flags a line with no edges for MAX_TICKS ticks.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int MAX_TICKS    = MAX_TICKS_DEFAULT,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_TICKS = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           PWM_IN,
  output logic [$clog2(MAX_TICKS+1)-1:0] PERIOD,
  output logic [$clog2(MAX_TICKS+1)-1:0] DUTY,
  output logic                           VALID,
  output logic                           STUCK,
  output logic                           LEVEL
);

  localparam int CW = cnt_width(MAX_TICKS);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILTER_DELAY = FILTER_TICKS;
`else
  localparam int FILTER_DELAY = 0 * FILTER_TICKS;
`endif
  // Cycles after reset until lvl reflects the pin; a line already high at
  // reset must not look like a rising edge.
  localparam int PRIME = SYNC_STAGES + FILTER_DELAY + 1;
  localparam int PW    = $clog2(PRIME + 1);

  logic lvl;

  pwm_input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES)
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    , .FILTER_TICKS(FILTER_TICKS)
`endif
  ) u_cond (
    .clk_i (CLK),
    .rst_i (RST),
    .pwm_i (PWM_IN),
    .lvl_o (lvl)
  );

  logic          lvl_q;
  logic [PW-1:0] prime_q;
  pwm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          valid_q, valid_d;
  logic          stuck_q, stuck_d;

  logic primed, rise, fall, at_max;
  assign primed = (prime_q == PW'(PRIME));
  assign rise   = primed &  lvl & ~lvl_q;
  assign fall   = primed & ~lvl &  lvl_q;
  assign at_max = (cnt_q == CW'(MAX_TICKS));

  // Previous level for edge detection, and the startup settle counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lvl_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      lvl_q <= lvl;
      if (!primed) prime_q <= prime_q + 1'b1;
    end
  end

  // Next-state: tick counter, measurement FSM and result registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = at_max ? cnt_q : cnt_q + 1'b1;
    hi_d     = hi_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    if (rise) cnt_d = CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          hi_d    = cnt_q;
        end else if (at_max) begin
          state_d = ST_IDLE;
          stuck_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d  = ST_HIGH;
          period_d = cnt_q;
          duty_d   = hi_q;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
        end else if (at_max) begin
          state_d = ST_IDLE;
          stuck_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any measurement in progress
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign PERIOD = period_q;
  assign DUTY   = duty_q;
  assign VALID  = valid_q;
  assign STUCK  = stuck_q;
  assign LEVEL  = lvl;

endmodule
